// File: rtl/parking_pkg.sv
// Shared definitions for the two-class parking controller: car class encoding,
// day length and the uni capacity schedule.
package parking_pkg;

  typedef enum logic {
    CLS_FREE = 1'b0,
    CLS_UNI  = 1'b1
  } car_class_e;

  localparam int HOURS_PER_DAY = 24;

  // Uni capacity for a given hour: flat before shrink_start, then one step
  // lower per hour (the first reduced hour already loses one step), floored.
  function automatic int uni_cap_at(input int hour, input int cap_start,
                                    input int cap_end, input int step,
                                    input int shrink_start);
    int cap;
    if (hour < shrink_start) return cap_start;
    cap = cap_start - step * (hour - shrink_start + 1);
    return (cap < cap_end) ? cap_end : cap;
  endfunction

endpackage

// File: rtl/parking_ctrl_v2_if.sv
// Event and status bundle of the parking controller. The environment drives
// entries/exits through master; the controller presents occupancy through slave.
interface parking_ctrl_v2_if #(
  parameter int CNT_W  = 10,
  parameter int HOUR_W = 5
);

  logic              car_entered;
  logic              is_uni_car_entered;
  logic              car_exited;
  logic              is_uni_car_exited;
  logic [HOUR_W-1:0] hour;
  logic [CNT_W-1:0]  uni_parked_car;
  logic [CNT_W-1:0]  free_parked_car;
  logic [CNT_W-1:0]  uni_overflow_car;
  logic [CNT_W-1:0]  uni_vacated_space;
  logic [CNT_W-1:0]  free_vacated_space;
  logic              uni_is_vacated_space;
  logic              free_is_vacated_space;
  logic              ja_nist;
  logic              faulty_exit;

  modport master (
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  hour, uni_parked_car, free_parked_car, uni_overflow_car,
           uni_vacated_space, free_vacated_space, uni_is_vacated_space,
           free_is_vacated_space, ja_nist, faulty_exit
  );

  modport slave (
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output hour, uni_parked_car, free_parked_car, uni_overflow_car,
           uni_vacated_space, free_vacated_space, uni_is_vacated_space,
           free_is_vacated_space, ja_nist, faulty_exit
  );

endinterface

// File: rtl/parking_hour_clock.sv
// Hour prescaler and hour-of-day counter; derives the current and next-hour
// capacities of both pools from the uni capacity schedule.
module parking_hour_clock
  import parking_pkg::*;
#(
  parameter int CNT_W           = 10,
  parameter int HOUR_W          = 5,
  parameter int TOTAL_CAP       = 700,
  parameter int UNI_CAP_START   = 500,
  parameter int UNI_CAP_END     = 200,
  parameter int UNI_STEP        = 50,
  parameter int START_HOUR      = 8,
  parameter int SHRINK_START    = 13,
  parameter int CYCLES_PER_HOUR = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic [HOUR_W-1:0] hour,
  output logic [CNT_W-1:0]  uni_cap,
  output logic [CNT_W-1:0]  free_cap,
  output logic [CNT_W-1:0]  uni_cap_nxt,
  output logic [CNT_W-1:0]  free_cap_nxt
);

  localparam int TICK_W = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_HOUR - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_DAY - 1);

  logic [TICK_W-1:0] tick;
  logic [HOUR_W-1:0] hour_nxt;
  logic              wrap;

  assign wrap = (tick == TICK_LAST);

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    hour_nxt = hour;
    if (wrap) hour_nxt = (hour == HOUR_LAST) ? '0 : hour + 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick <= '0;
      hour <= HOUR_W'(START_HOUR);
    end else begin
      tick <= wrap ? '0 : tick + 1'b1;
      hour <= hour_nxt;
    end
  end

  assign uni_cap      = CNT_W'(uni_cap_at(int'(hour), UNI_CAP_START, UNI_CAP_END,
                                          UNI_STEP, SHRINK_START));
  assign uni_cap_nxt  = CNT_W'(uni_cap_at(int'(hour_nxt), UNI_CAP_START, UNI_CAP_END,
                                          UNI_STEP, SHRINK_START));
  assign free_cap     = CNT_W'(TOTAL_CAP) - uni_cap;
  assign free_cap_nxt = CNT_W'(TOTAL_CAP) - uni_cap_nxt;

endmodule

// File: rtl/parking_ctrl_v2.sv
// Two-class parking occupancy controller with an hour-driven capacity schedule.
// Define UNI_OVERFLOW_EN to let uni cars rejected by a full uni pool park in free spaces.
module parking_ctrl_v2
  import parking_pkg::*;
#(
  parameter int CNT_W           = 10,
  parameter int HOUR_W          = 5,
  parameter int TOTAL_CAP       = 700,
  parameter int UNI_CAP_START   = 500,
  parameter int UNI_CAP_END     = 200,
  parameter int UNI_STEP        = 50,
  parameter int START_HOUR      = 8,
  parameter int SHRINK_START    = 13,
  parameter int CYCLES_PER_HOUR = 16
) (
  input  logic             clock,
  input  logic             reset,
  parking_ctrl_v2_if.slave bus
);

  localparam logic [CNT_W-1:0] RST_UNI_CAP =
    CNT_W'(uni_cap_at(START_HOUR, UNI_CAP_START, UNI_CAP_END, UNI_STEP, SHRINK_START));
  localparam logic [CNT_W-1:0] RST_FREE_CAP = CNT_W'(TOTAL_CAP) - RST_UNI_CAP;

  logic [HOUR_W-1:0] hour;
  logic [CNT_W-1:0]  uni_cap, free_cap, uni_cap_nxt, free_cap_nxt;

  parking_hour_clock #(
    .CNT_W          (CNT_W),
    .HOUR_W         (HOUR_W),
    .TOTAL_CAP      (TOTAL_CAP),
    .UNI_CAP_START  (UNI_CAP_START),
    .UNI_CAP_END    (UNI_CAP_END),
    .UNI_STEP       (UNI_STEP),
    .START_HOUR     (START_HOUR),
    .SHRINK_START   (SHRINK_START),
    .CYCLES_PER_HOUR(CYCLES_PER_HOUR)
  ) u_hour_clock (
    .clock       (clock),
    .reset       (reset),
    .hour        (hour),
    .uni_cap     (uni_cap),
    .free_cap    (free_cap),
    .uni_cap_nxt (uni_cap_nxt),
    .free_cap_nxt(free_cap_nxt)
  );

  logic [CNT_W-1:0] uni_cnt, free_cnt, ovf_cnt, uni_vac, free_vac;
  logic             uni_is_vac, free_is_vac, ja_nist_q, faulty_q;

  logic [CNT_W:0] uni_w, free_w, ovf_w, uni_vac_w, free_vac_w;
  logic           reject, fault;
  car_class_e     entry_cls, exit_cls;

  assign entry_cls = car_class_e'(bus.is_uni_car_entered);
  assign exit_cls  = car_class_e'(bus.is_uni_car_exited);

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] v);
    return v[CNT_W] ? '1 : v[CNT_W-1:0];
  endfunction

  // Exit is resolved before entry so a departing car frees room for an
  // arrival in the same cycle; admission uses the capacity of the current hour.
  always_comb begin
    uni_w  = {1'b0, uni_cnt};
    free_w = {1'b0, free_cnt};
`ifdef UNI_OVERFLOW_EN
    ovf_w  = {1'b0, ovf_cnt};
`else
    ovf_w  = '0;
`endif
    reject = 1'b0;
    fault  = 1'b0;

    if (bus.car_exited) begin
      if (exit_cls == CLS_UNI) begin
`ifdef UNI_OVERFLOW_EN
        if (ovf_w != '0)      ovf_w = ovf_w - 1'b1;
        else if (uni_w != '0) uni_w = uni_w - 1'b1;
        else                  fault = 1'b1;
`else
        if (uni_w != '0) uni_w = uni_w - 1'b1;
        else             fault = 1'b1;
`endif
      end else begin
        if (free_w != '0) free_w = free_w - 1'b1;
        else              fault  = 1'b1;
      end
    end

    if (bus.car_entered) begin
      if (entry_cls == CLS_UNI) begin
        if (uni_w < {1'b0, uni_cap}) uni_w = uni_w + 1'b1;
`ifdef UNI_OVERFLOW_EN
        else if (free_w + ovf_w < {1'b0, free_cap}) ovf_w = ovf_w + 1'b1;
`endif
        else reject = 1'b1;
      end else begin
        if (free_w + ovf_w < {1'b0, free_cap}) free_w = free_w + 1'b1;
        else                                   reject = 1'b1;
      end
    end
  end

  // Vacancy is reported against the capacity of the hour that follows the edge.
  always_comb begin
    uni_vac_w  = '0;
    free_vac_w = '0;
    if ({1'b0, uni_cap_nxt} > uni_w) uni_vac_w = {1'b0, uni_cap_nxt} - uni_w;
    if ({1'b0, free_cap_nxt} > free_w + ovf_w)
      free_vac_w = {1'b0, free_cap_nxt} - free_w - ovf_w;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uni_cnt     <= '0;
      free_cnt    <= '0;
      ovf_cnt     <= '0;
      uni_vac     <= RST_UNI_CAP;
      free_vac    <= RST_FREE_CAP;
      uni_is_vac  <= (RST_UNI_CAP != '0);
      free_is_vac <= (RST_FREE_CAP != '0);
      ja_nist_q   <= 1'b0;
      faulty_q    <= 1'b0;
    end else begin
      uni_cnt     <= sat(uni_w);
      free_cnt    <= sat(free_w);
      ovf_cnt     <= sat(ovf_w);
      uni_vac     <= sat(uni_vac_w);
      free_vac    <= sat(free_vac_w);
      uni_is_vac  <= (uni_vac_w != '0);
      free_is_vac <= (free_vac_w != '0);
      ja_nist_q   <= reject;
      faulty_q    <= fault;
    end
  end

  assign bus.hour                  = hour;
  assign bus.uni_parked_car        = uni_cnt;
  assign bus.free_parked_car       = free_cnt;
  assign bus.uni_overflow_car      = ovf_cnt;
  assign bus.uni_vacated_space     = uni_vac;
  assign bus.free_vacated_space    = free_vac;
  assign bus.uni_is_vacated_space  = uni_is_vac;
  assign bus.free_is_vacated_space = free_is_vac;
  assign bus.ja_nist               = ja_nist_q;
  assign bus.faulty_exit           = faulty_q;

endmodule

// File: tb/tb_parking_ctrl_v2.sv
// Scoreboard bench for parking_ctrl_v2: a driver pushes reference-model results,
// a monitor pops and compares them one clock later. Honours UNI_OVERFLOW_EN.
module tb_parking_ctrl_v2;

  localparam int CNT_W           = 10;
  localparam int HOUR_W          = 5;
  localparam int TOTAL_CAP       = 700;
  localparam int UNI_CAP_START   = 500;
  localparam int UNI_CAP_END     = 200;
  localparam int UNI_STEP        = 50;
  localparam int START_HOUR      = 8;
  localparam int SHRINK_START    = 13;
  localparam int CPH             = 16;
`ifdef UNI_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    int hour;
    int uni;
    int free;
    int ovf;
    int uvac;
    int fvac;
    bit uisv;
    bit fisv;
    bit jan;
    bit flt;
  } exp_t;

  logic clock;
  logic reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_cyc, m_uni, m_free, m_ovf;

  parking_ctrl_v2_if #(.CNT_W(CNT_W), .HOUR_W(HOUR_W)) bus ();

  parking_ctrl_v2 dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: hour follows from elapsed cycles, capacity from the schedule.
  function automatic int ref_hour(input int cyc);
    return (START_HOUR + cyc / CPH) % 24;
  endfunction

  function automatic int ref_uni_cap(input int h);
    int v;
    if (h < SHRINK_START) return UNI_CAP_START;
    v = UNI_CAP_START - UNI_STEP * (h - SHRINK_START + 1);
    return (v < UNI_CAP_END) ? UNI_CAP_END : v;
  endfunction

  function automatic exp_t make_exp(input bit jan, input bit flt);
    exp_t e;
    int   ucap, fcap;
    ucap   = ref_uni_cap(ref_hour(m_cyc));
    fcap   = TOTAL_CAP - ucap;
    e.hour = ref_hour(m_cyc);
    e.uni  = m_uni;
    e.free = m_free;
    e.ovf  = m_ovf;
    e.uvac = (ucap > m_uni) ? ucap - m_uni : 0;
    e.fvac = (fcap > m_free + m_ovf) ? fcap - m_free - m_ovf : 0;
    e.uisv = (e.uvac != 0);
    e.fisv = (e.fvac != 0);
    e.jan  = jan;
    e.flt  = flt;
    return e;
  endfunction

  task automatic model_step(input bit ent, input bit eu, input bit ex, input bit xu);
    int ucap, fcap;
    bit jan;
    bit flt;
    jan  = 1'b0;
    flt  = 1'b0;
    ucap = ref_uni_cap(ref_hour(m_cyc));
    fcap = TOTAL_CAP - ucap;
    if (ex) begin
      if (xu) begin
        if (m_ovf > 0)      m_ovf--;
        else if (m_uni > 0) m_uni--;
        else                flt = 1'b1;
      end else begin
        if (m_free > 0) m_free--;
        else            flt = 1'b1;
      end
    end
    if (ent) begin
      if (eu) begin
        if (m_uni < ucap)                          m_uni++;
        else if (OVF_EN && (m_free + m_ovf < fcap)) m_ovf++;
        else                                       jan = 1'b1;
      end else begin
        if (m_free + m_ovf < fcap) m_free++;
        else                       jan = 1'b1;
      end
    end
    m_cyc++;
    exp_q.push_back(make_exp(jan, flt));
  endtask

  task automatic drive(input bit rst_v, input bit ent, input bit eu,
                       input bit ex, input bit xu);
    @(negedge clock);
    reset                  = rst_v;
    bus.car_entered        = ent;
    bus.is_uni_car_entered = eu;
    bus.car_exited         = ex;
    bus.is_uni_car_exited  = xu;
    if (!rst_v) begin
      m_cyc  = 0;
      m_uni  = 0;
      m_free = 0;
      m_ovf  = 0;
      exp_q.push_back(make_exp(1'b0, 1'b0));
    end else begin
      model_step(ent, eu, ex, xu);
    end
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, $urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hour",             bus.hour,                  e.hour);
        check("uni_parked_car",   bus.uni_parked_car,        e.uni);
        check("free_parked_car",  bus.free_parked_car,       e.free);
        check("uni_overflow_car", bus.uni_overflow_car,      e.ovf);
        check("uni_vacated",      bus.uni_vacated_space,     e.uvac);
        check("free_vacated",     bus.free_vacated_space,    e.fvac);
        check("uni_is_vacated",   bus.uni_is_vacated_space,  e.uisv);
        check("free_is_vacated",  bus.free_is_vacated_space, e.fisv);
        check("ja_nist",          bus.ja_nist,               e.jan);
        check("faulty_exit",      bus.faulty_exit,           e.flt);
      end
    end
  end

  initial begin : stimulus
    int guard;
    reset                  = 1'b1;
    bus.car_entered        = 1'b0;
    bus.is_uni_car_entered = 1'b0;
    bus.car_exited         = 1'b0;
    bus.is_uni_car_exited  = 1'b0;
    #2 reset = 1'b0;

    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exits from empty pools, then a quiet cycle to see the pulse drop.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Free fill across the day rollover, where free capacity drops below occupancy.
    repeat (300) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Long uni fill: crosses the shrink schedule and the 200 floor, saturating vacancy.
    repeat (600) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Same-class entry and exit together while the uni pool is full.
    repeat (20) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Drain both pools past empty, then same-class pairs starting from zero.
    repeat (700) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (700) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    drive_random(1500);

    // Asynchronous reset in the middle of traffic, then resume.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_random(200);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    #2;
    check("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
